load_sequencer: RTL and testbench
=================================

LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd100000, the maximum number of cycles to wait for dma_done per transfer.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to load N, e, R_N and R2_N.
REQ-005 SHALL have port dma_idle, input, 1, which is high when the DMA can accept a new transfer.
REQ-006 SHALL have port dma_done, input, 1, a one-cycle pulse marking dma_rx_data as valid.
REQ-007 SHALL have port dma_error, input, 1, a one-cycle pulse marking transfer failure.
REQ-008 SHALL have port dma_rx_start, output, 1, a one-cycle pulse that starts a DMA read.
REQ-009 SHALL have port loading_state, output, 32, the current load code consumed by data_preparation.
REQ-010 SHALL have port busy, output, 1, high while a load sequence is in progress.
REQ-011 SHALL have port load_done, output, 1, a one-cycle pulse when all four operands are loaded.
REQ-012 SHALL have port load_error, output, 1, a sticky error flag.

Function
REQ-013 SHALL implement the states IDLE, N, E, RN, R2N, DONE and ERR.
REQ-014 SHALL drive loading_state per state: IDLE=0x00, N=0x09, E=0x0A, RN=0x0B, R2N=0x0C, DONE=0x0D, ERR=0x0F; the output is registered and glitch-free.
REQ-015 SHALL split each load state into two phases, REQ and WAIT, without changing the value of loading_state.
REQ-016 SHALL, from IDLE with start=1, enter N/REQ on the next cycle; busy goes high in the same cycle and load_error clears.
REQ-017 SHALL, in REQ with dma_idle=1, pulse dma_rx_start for exactly one cycle and move to WAIT; with dma_idle=0 it stays in REQ with no pulse.
REQ-018 SHALL, in WAIT with dma_done=1, hold loading_state at the current code during that cycle so data_preparation captures the data; on the next cycle it advances N->E->RN->R2N->DONE, entering the next state in REQ.
REQ-019 SHALL, in DONE, assert load_done for exactly one cycle, then return to IDLE (loading_state=0x00, busy=0).
REQ-020 SHALL, in WAIT with dma_error=1, go to ERR and set load_error; if dma_error and dma_done arrive in the same cycle, the error wins.
REQ-021 SHALL use a 32-bit wait counter that clears on entry to WAIT and increments each WAIT cycle; when the count reaches TIMEOUT_CYCLES-1 without dma_done, it goes to ERR and sets load_error.
REQ-022 SHALL, in ERR, keep busy=0 and loading_state=0x0F until start, which clears load_error and enters N/REQ.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL ignore dma_done and dma_error in REQ, IDLE, DONE and ERR.
REQ-025 SHALL never have more than one dma_rx_start outstanding; a second pulse requires dma_done or an error in between.

Reset
REQ-026 SHALL, with resetn=0 at any time including mid-transfer, immediately force IDLE, loading_state=0x00, dma_rx_start=0, busy=0, load_done=0, load_error=0 and wait counter=0.
REQ-027 SHALL, after reset release, wait for a new start; an in-flight dma_done is ignored.

Structure
REQ-028 SHALL define the load-state codes (0x00, 0x09–0x0D, 0x0F) as constants in a shared package that data_preparation also uses.
REQ-029 SHALL be implemented as one module with no sub-modules; the timeout counter is inline.

Verification
REQ-030 SHALL cover a nominal load: start, dma_idle=1, dma_done 5 cycles after each dma_rx_start -> 4 dma_rx_start pulses, loading_state steps 0x09,0x0A,0x0B,0x0C,0x0D,0x00, one load_done pulse.
REQ-031 SHALL cover a DMA error: dma_error during E/WAIT -> loading_state=0x0F, load_error=1, no further dma_rx_start; a later start restarts at 0x09 with load_error=0.
REQ-032 SHALL cover timeout: TIMEOUT_CYCLES=16 and no dma_done in N -> ERR exactly 16 cycles after WAIT entry.
REQ-033 SHALL cover busy DMA: dma_idle=0 for 10 cycles in RN/REQ -> no dma_rx_start until dma_idle rises, then exactly one pulse.
REQ-034 SHALL cover reset mid-transfer: resetn low during R2N/WAIT -> all outputs reset at once; a dma_done after release is ignored.
REQ-035 SHALL cover edge events: dma_done and dma_error in the same cycle -> ERR; start while busy -> no effect on the sequence.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// rtl/load_sequencer_pkg.sv - shared load-state codes and phase type for the operand loader
package load_sequencer_pkg;

  // Load-state codes; data_preparation decodes these same values
  localparam logic [7:0] LS_IDLE = 8'h00;
  localparam logic [7:0] LS_N    = 8'h09;
  localparam logic [7:0] LS_E    = 8'h0A;
  localparam logic [7:0] LS_RN   = 8'h0B;
  localparam logic [7:0] LS_R2N  = 8'h0C;
  localparam logic [7:0] LS_DONE = 8'h0D;
  localparam logic [7:0] LS_ERR  = 8'h0F;

  // Each operand load is a request phase followed by a wait-for-data phase
  typedef enum logic {
    PH_REQ  = 1'b0,
    PH_WAIT = 1'b1
  } phase_t;

  // Operand order: N -> e -> R_N -> R2_N -> done
  function automatic logic [7:0] next_load_code(input logic [7:0] code);
    case (code)
      LS_N:    return LS_E;
      LS_E:    return LS_RN;
      LS_RN:   return LS_R2N;
      LS_R2N:  return LS_DONE;
      default: return LS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/load_sequencer.sv
// rtl/load_sequencer.sv - sequences DMA reads of N, e, R_N and R2_N with timeout and error capture
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        dma_idle,
  input  logic        dma_done,
  input  logic        dma_error,
  output logic        dma_rx_start,
  output logic [31:0] loading_state,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  // The state register holds the load code itself, so loading_state is a
  // direct register output with no decode between flop and port.
  logic [7:0]  state;
  phase_t      phase;
  logic [31:0] wait_cnt;

  assign loading_state = {24'h000000, state};

  // Main sequencer: state, phase, wait counter and all registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= LS_IDLE;
      phase        <= PH_REQ;
      wait_cnt     <= 32'd0;
      dma_rx_start <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      dma_rx_start <= 1'b0;
      load_done    <= 1'b0;
      case (state)
        LS_IDLE, LS_ERR: begin
          if (start) begin
            state      <= LS_N;
            phase      <= PH_REQ;
            busy       <= 1'b1;
            load_error <= 1'b0;
          end
        end
        LS_DONE: begin
          state <= LS_IDLE;
          phase <= PH_REQ;
          busy  <= 1'b0;
        end
        LS_N, LS_E, LS_RN, LS_R2N: begin
          if (phase == PH_REQ) begin
            // Only one read in flight: the next request is issued only
            // after this one completes or fails.
            if (dma_idle) begin
              dma_rx_start <= 1'b1;
              phase        <= PH_WAIT;
              wait_cnt     <= 32'd0;
            end
          end else begin
            if (dma_error) begin
              state      <= LS_ERR;
              phase      <= PH_REQ;
              busy       <= 1'b0;
              load_error <= 1'b1;
            end else if (dma_done) begin
              // Code holds through the done cycle so the data is captured
              // under the right operand; it advances on the next edge.
              state <= next_load_code(state);
              phase <= PH_REQ;
              if (next_load_code(state) == LS_DONE) begin
                load_done <= 1'b1;
              end
            end else if (wait_cnt == TIMEOUT_LAST) begin
              state      <= LS_ERR;
              phase      <= PH_REQ;
              busy       <= 1'b0;
              load_error <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
        end
        default: begin
          state <= LS_IDLE;
          phase <= PH_REQ;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// tb/tb_load_sequencer.sv - directed self-checking bench for load_sequencer
module tb_load_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        dma_idle;
  logic        dma_done;
  logic        dma_error;
  logic        dma_rx_start;
  logic [31:0] loading_state;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int done_cnt = 0;
  int rx_base;
  int done_base;

  load_sequencer #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .dma_idle     (dma_idle),
    .dma_done     (dma_done),
    .dma_error    (dma_error),
    .dma_rx_start (dma_rx_start),
    .loading_state(loading_state),
    .busy         (busy),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (resetn && dma_rx_start) rx_cnt++;
    if (resetn && load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn    = 1'b0;
    start     = 1'b0;
    dma_idle  = 1'b1;
    dma_done  = 1'b0;
    dma_error = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    tick;
  endtask

  task automatic start_load(input string tag);
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_ls"}, loading_state, 32'h09);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_err"}, 32'(load_error), 32'd0);
  endtask

  // From code/REQ with dma_idle=1: pulse, dma_done 5 cycles later, advance
  task automatic load_step(input logic [31:0] code, input logic [31:0] next_code);
    tick;
    check("step_rx_pulse", 32'(dma_rx_start), 32'd1);
    check("step_ls_wait", loading_state, code);
    tick;
    check("step_rx_single", 32'(dma_rx_start), 32'd0);
    repeat (4) tick;
    dma_done = 1'b1;
    check("step_ls_hold", loading_state, code);
    tick;
    dma_done = 1'b0;
    check("step_ls_next", loading_state, next_code);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset;
    check("rst_ls", loading_state, 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx", 32'(dma_rx_start), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);

    // Nominal load
    rx_base = rx_cnt;
    done_base = done_cnt;
    start_load("nom_start");
    load_step(32'h09, 32'h0A);
    load_step(32'h0A, 32'h0B);
    load_step(32'h0B, 32'h0C);
    load_step(32'h0C, 32'h0D);
    check("nom_load_done", 32'(load_done), 32'd1);
    check("nom_busy_done", 32'(busy), 32'd1);
    tick;
    check("nom_ls_idle", loading_state, 32'h00);
    check("nom_busy_idle", 32'(busy), 32'd0);
    check("nom_done_low", 32'(load_done), 32'd0);
    tick;
    check("nom_rx_count", 32'(rx_cnt - rx_base), 32'd4);
    check("nom_done_count", 32'(done_cnt - done_base), 32'd1);

    // DMA error in E/WAIT
    do_reset;
    start_load("err_start");
    load_step(32'h09, 32'h0A);
    tick;
    tick;
    dma_error = 1'b1;
    tick;
    dma_error = 1'b0;
    check("err_ls", loading_state, 32'h0F);
    check("err_flag", 32'(load_error), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    rx_base = rx_cnt;
    repeat (5) tick;
    check("err_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("err_ls_hold", loading_state, 32'h0F);
    start_load("err_restart");

    // Timeout in N/WAIT
    do_reset;
    start_load("to_start");
    tick;
    check("to_rx", 32'(dma_rx_start), 32'd1);
    repeat (15) tick;
    check("to_before", loading_state, 32'h09);
    tick;
    check("to_fire", loading_state, 32'h0F);
    check("to_err", 32'(load_error), 32'd1);

    // Busy DMA in RN/REQ
    do_reset;
    start_load("bz_start");
    load_step(32'h09, 32'h0A);
    tick;
    repeat (4) tick;
    dma_done = 1'b1;
    dma_idle = 1'b0;
    tick;
    dma_done = 1'b0;
    check("bz_ls_rn", loading_state, 32'h0B);
    rx_base = rx_cnt;
    repeat (10) tick;
    check("bz_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    dma_idle = 1'b1;
    tick;
    check("bz_rx_pulse", 32'(dma_rx_start), 32'd1);
    repeat (3) tick;
    check("bz_rx_count", 32'(rx_cnt - rx_base), 32'd1);

    // Reset mid-transfer in R2N/WAIT
    do_reset;
    start_load("mr_start");
    load_step(32'h09, 32'h0A);
    load_step(32'h0A, 32'h0B);
    load_step(32'h0B, 32'h0C);
    tick;
    check("mr_pre_rx", 32'(dma_rx_start), 32'd1);
    resetn = 1'b0;
    #1;
    check("mr_ls", loading_state, 32'h00);
    check("mr_rx", 32'(dma_rx_start), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    tick;
    resetn = 1'b1;
    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    rx_base = rx_cnt;
    repeat (3) tick;
    check("mr_post_ls", loading_state, 32'h00);
    check("mr_post_busy", 32'(busy), 32'd0);
    check("mr_post_rx", 32'(rx_cnt - rx_base), 32'd0);

    // dma_done and dma_error together, then start while busy
    do_reset;
    start_load("ed_start");
    tick;
    tick;
    dma_done = 1'b1;
    dma_error = 1'b1;
    tick;
    dma_done = 1'b0;
    dma_error = 1'b0;
    check("ed_both_ls", loading_state, 32'h0F);
    check("ed_both_err", 32'(load_error), 32'd1);
    rx_base = rx_cnt;
    done_base = done_cnt;
    start_load("ed_restart");
    tick;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ed_busy_ls", loading_state, 32'h09);
    check("ed_busy_busy", 32'(busy), 32'd1);
    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    check("ed_adv_ls", loading_state, 32'h0A);
    load_step(32'h0A, 32'h0B);
    load_step(32'h0B, 32'h0C);
    load_step(32'h0C, 32'h0D);
    tick;
    check("ed_end_ls", loading_state, 32'h00);
    tick;
    check("ed_rx_count", 32'(rx_cnt - rx_base), 32'd4);
    check("ed_done_count", 32'(done_cnt - done_base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
